act_requant_pack: RTL and testbench

- Consumer at the output of the activation stage. Takes the INT32 activation stream (valid pulse plus data) and requantizes each value to INT8 with a multiply, a rounding arithmetic shift and saturation.
- Packs four INT8 results into one 32-bit word and buffers the words in a FIFO.
- Presents the words to the output-buffer writer with a valid/ready handshake and an end-of-tile flush.

---
 rtl/act_requant_pkg.sv | 39 +++
 rtl/dpu_word_fifo.sv | 65 ++++++
 rtl/act_requant_pack.sv | 180 ++++++++++++++++++
 tb/tb_act_requant_pack.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_requant_pkg.sv
// Shared types, widths and the INT8 saturation helper for the activation requantizer/packer.
package act_requant_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned PROD_W = 48;

   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   typedef logic [ACC_W-1:0] word_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      EMIT  = 2'd2
   } fsm_t;

   typedef struct packed {
      logic  last;
      word_t data;
   } entry_t;

   // Clamp a shifted product into the signed INT8 range.
   function automatic logic [BYTE_W-1:0] sat_int8(input logic signed [PROD_W-1:0] r);
      logic signed [PROD_W-1:0] hi;
      logic signed [PROD_W-1:0] lo;
      hi = PROD_W'(INT8_MAX);
      lo = PROD_W'(INT8_MIN);
      if (r > hi) begin
         return BYTE_W'(INT8_MAX);
      end else if (r < lo) begin
         return BYTE_W'(INT8_MIN);
      end
      return BYTE_W'(r);
   endfunction

endpackage

// File: rtl/dpu_word_fifo.sv
// Synchronous word FIFO with first-word-fall-through head; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module dpu_word_fifo
   import act_requant_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CW'(DEPTH));
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/act_requant_pack.sv
// INT32 -> INT8 requantizer (multiply, arithmetic shift, saturate) packing four bytes per
// word into a FIFO with flush. Define REQUANT_ROUND_EN for round-half-up, else truncation.
module act_requant_pack
   import act_requant_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned SCALE_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [ACC_W-1:0]            in_data,
   output logic                        in_ready,
   input  logic [SCALE_W-1:0]          cfg_scale,
   input  logic [4:0]                  cfg_shift,
   input  logic                        flush,
   output logic                        flush_done,
   output logic                        out_valid,
   output logic [ACC_W-1:0]            out_data,
   output logic                        out_last,
   input  logic                        out_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SH_W   = 5;
   localparam int unsigned LANE_W = $clog2(LANES);

   fsm_t                            state_q, state_d;
   logic                            s1_vld_q, s1_vld_d;
   logic signed [PROD_W-1:0]        s1_prod_q, s1_prod_d;
   logic [SH_W-1:0]                 s1_shift_q, s1_shift_d;
   logic                            s2_vld_q, s2_vld_d;
   logic [BYTE_W-1:0]               s2_byte_q, s2_byte_d;
   logic [LANE_W-1:0]               lane_cnt_q, lane_cnt_d;
   logic [LANES-1:0][BYTE_W-1:0]    lanes_q, lanes_d;
   logic                            flush_done_q, flush_done_d;
   logic                            overflow_q, overflow_d;

   logic                            accept;
   logic signed [PROD_W-1:0]        prod_in;
   logic signed [PROD_W-1:0]        rounded;
   logic signed [PROD_W-1:0]        shifted;
   logic [LANES-1:0][BYTE_W-1:0]    partial;
   logic                            push_en;
   entry_t                          push_entry;
   entry_t                          head;
   logic                            pop;
   logic                            fifo_full;
   logic                            fifo_empty;
   logic [CNT_W-1:0]                fifo_cnt;
`ifdef REQUANT_ROUND_EN
   logic signed [PROD_W-1:0]        rnd;
`endif

   // Datapath: S1 multiply, S2 round/shift/saturate.
   always_comb begin
      accept     = in_valid && (state_q == RUN);
      prod_in    = PROD_W'($signed(in_data)) * PROD_W'($signed({1'b0, cfg_scale}));
      s1_vld_d   = accept;
      s1_prod_d  = accept ? prod_in : s1_prod_q;
      s1_shift_d = accept ? cfg_shift : s1_shift_q;
`ifdef REQUANT_ROUND_EN
      rnd        = (s1_shift_q != '0) ? (PROD_W'(1) << (s1_shift_q - SH_W'(1))) : '0;
      rounded    = s1_prod_q + rnd;
`else
      rounded    = s1_prod_q;
`endif
      shifted    = rounded >>> s1_shift_q;
      s2_vld_d   = s1_vld_q;
      s2_byte_d  = s1_vld_q ? sat_int8(shifted) : s2_byte_q;
   end

   // Packer, FIFO push selection and flush FSM.
   always_comb begin
      state_d      = state_q;
      lanes_d      = lanes_q;
      lane_cnt_d   = lane_cnt_q;
      flush_done_d = 1'b0;
      push_en      = 1'b0;
      push_entry   = '0;
      pop          = !fifo_empty && out_ready;

      for (int unsigned k = 0; k < LANES; k++) begin
         partial[k] = (LANE_W'(k) < lane_cnt_q) ? lanes_q[k] : '0;
      end

      if (s2_vld_q) begin
         lanes_d[lane_cnt_q] = s2_byte_q;
         if (lane_cnt_q == LANE_W'(LANES - 1)) begin
            push_en    = 1'b1;
            push_entry = '{last: 1'b0, data: word_t'(lanes_d)};
            lane_cnt_d = '0;
         end else begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
         end
      end

      case (state_q)
         RUN: begin
            if (flush) state_d = DRAIN;
         end
         DRAIN: begin
            if (!s1_vld_q && !s2_vld_q) begin
               if (lane_cnt_q == '0) begin
                  flush_done_d = 1'b1;
                  state_d      = RUN;
               end else begin
                  state_d = EMIT;
               end
            end
         end
         EMIT: begin
            // Stall instead of dropping the closing word.
            if (!fifo_full || pop) begin
               push_en      = 1'b1;
               push_entry   = '{last: 1'b1, data: word_t'(partial)};
               lane_cnt_d   = '0;
               flush_done_d = 1'b1;
               state_d      = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      overflow_d = overflow_q
                 || (push_en && fifo_full && !pop)
                 || (in_valid && (state_q != RUN));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         s1_vld_q     <= 1'b0;
         s1_prod_q    <= '0;
         s1_shift_q   <= '0;
         s2_vld_q     <= 1'b0;
         s2_byte_q    <= '0;
         lane_cnt_q   <= '0;
         lanes_q      <= '0;
         flush_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         s1_vld_q     <= s1_vld_d;
         s1_prod_q    <= s1_prod_d;
         s1_shift_q   <= s1_shift_d;
         s2_vld_q     <= s2_vld_d;
         s2_byte_q    <= s2_byte_d;
         lane_cnt_q   <= lane_cnt_d;
         lanes_q      <= lanes_d;
         flush_done_q <= flush_done_d;
         overflow_q   <= overflow_d;
      end
   end

   dpu_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_en),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (fifo_cnt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign in_ready   = !rst && (state_q == RUN) && (fifo_cnt <= CNT_W'(FIFO_DEPTH - 2));
   assign out_valid  = !fifo_empty;
   assign out_data   = head.data;
   assign out_last   = head.last;
   assign fifo_count = fifo_cnt;
   assign flush_done = flush_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_act_requant_pack.sv
// Self-checking bench: directed scenarios plus randomized traffic against a word-level model.
module tb_act_requant_pack;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned SCALE_W = 16;
   localparam int unsigned CW      = $clog2(DEPTH) + 1;
`ifdef REQUANT_ROUND_EN
   localparam logic [7:0] EXP_M100 = 8'hF7;
`else
   localparam logic [7:0] EXP_M100 = 8'hF6;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic [31:0]        in_data = '0;
   logic               in_ready;
   logic [SCALE_W-1:0] cfg_scale = '0;
   logic [4:0]         cfg_shift = '0;
   logic               flush = 1'b0;
   logic               flush_done;
   logic               out_valid;
   logic [31:0]        out_data;
   logic               out_last;
   logic               out_ready = 1'b0;
   logic [CW-1:0]      fifo_count;
   logic               overflow;

   int n_total = 0;
   int n_bad   = 0;
   int n_flush_exp = 0;
   int n_fd_seen   = 0;
   int n_drop_m    = 0;
   bit rnd_ready   = 0;
   bit hold_mode   = 0;

   logic [32:0] exp_q[$];
   logic [7:0]  lanes_m[$];

   act_requant_pack #(.FIFO_DEPTH(DEPTH), .SCALE_W(SCALE_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .flush(flush), .flush_done(flush_done),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference requantization in plain integer arithmetic.
   function automatic logic [7:0] ref_byte(input int x, input int sc, input int sh);
      longint p;
      longint r;
      p = longint'(x) * longint'(sc);
`ifdef REQUANT_ROUND_EN
      if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
`endif
      r = p >>> sh;
      if (r > 127) r = 127;
      else if (r < -128) r = -128;
      return 8'(r);
   endfunction

   function automatic void model_push(input logic [31:0] w, input logic last);
      if (hold_mode && exp_q.size() >= DEPTH) n_drop_m++;
      else exp_q.push_back({last, w});
   endfunction

   function automatic logic [31:0] model_word();
      logic [31:0] w = '0;
      for (int k = 0; k < lanes_m.size(); k++) w[8*k +: 8] = lanes_m[k];
      return w;
   endfunction

   function automatic void model_accept(input int x, input int sc, input int sh);
      lanes_m.push_back(ref_byte(x, sc, sh));
      if (lanes_m.size() == 4) begin
         model_push(model_word(), 1'b0);
         lanes_m.delete();
      end
   endfunction

   function automatic void model_flush();
      if (lanes_m.size() > 0) model_push(model_word(), 1'b1);
      lanes_m.delete();
      n_flush_exp++;
   endfunction

   // Output compare: every popped word must match the model queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (flush_done) n_fd_seen++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               chk("out_data", 64'(out_data), 64'(e[31:0]));
               chk("out_last", 64'(out_last), 64'(e[32]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_sample(input int x, input int sc, input int sh);
      in_valid  = 1'b1;
      in_data   = 32'(x);
      cfg_scale = SCALE_W'(sc);
      cfg_shift = 5'(sh);
      model_accept(x, sc, sh);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      model_flush();
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_flush_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (flush_done) begin
            seen = 1;
            break;
         end
         tick();
      end
      chk(name, 64'(seen), 64'd1);
   endtask

   task automatic wait_drain(input string name);
      bit ok = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !out_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
      out_ready = 1'b0;
      chk(name, 64'(ok), 64'd1);
      chk({name, "_count"}, 64'(fifo_count), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      rnd_ready = 0;
      hold_mode = 0;
      tick();
      tick();
      exp_q.delete();
      lanes_m.delete();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int drop_at;
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_flush_done", 64'(flush_done), 64'd0);
      rst = 1'b0;
      tick();
      chk("rel_in_ready", 64'(in_ready), 64'd1);

      // Pass-through and push latency.
      drive_sample(5, 1, 0);
      drive_sample(-3, 1, 0);
      drive_sample(127, 1, 0);
      drive_sample(200, 1, 0);
      chk("pt_lat1", 64'(out_valid), 64'd0);
      tick();
      chk("pt_lat2", 64'(out_valid), 64'd0);
      tick();
      chk("pt_lat3", 64'(out_valid), 64'd1);
      chk("pt_data", 64'(out_data), 64'h7F7FFD05);
      chk("pt_last", 64'(out_last), 64'd0);
      wait_drain("pt_drain");

      // Rounding and negative saturation, closed by a flush.
      drive_sample(-100, 3, 5);
      drive_sample(-1000, 1, 0);
      flush_pulse();
      wait_flush_done("rnd_flush_done");
      chk("rnd_data", 64'(out_data), 64'({16'h0, 8'h80, EXP_M100}));
      chk("rnd_last", 64'(out_last), 64'd1);
      wait_drain("rnd_drain");

      // Flush of a partial word, then a flush with nothing pending.
      drive_sample(1, 1, 0);
      drive_sample(2, 1, 0);
      flush_pulse();
      wait_flush_done("fl_done1");
      chk("fl_valid", 64'(out_valid), 64'd1);
      chk("fl_data", 64'(out_data), 64'h00000201);
      chk("fl_last", 64'(out_last), 64'd1);
      tick();
      flush_pulse();
      wait_flush_done("fl_done2");
      tick();
      chk("fl_empty_count", 64'(fifo_count), 64'd1);
      wait_drain("fl_drain");

      // Backpressure: 20 samples into a stalled FIFO of 4.
      do_reset();
      hold_mode = 1;
      drop_at = -1;
      chk("bp_ready_start", 64'(in_ready), 64'd1);
      for (int i = 0; i < 20; i++) begin
         if (!in_ready && drop_at < 0) drop_at = int'(fifo_count);
         drive_sample(int'($urandom_range(0, 300)) - 150, 1, 0);
      end
      for (int i = 0; i < 4; i++) tick();
      chk("bp_drop_at", 64'(drop_at), 64'd3);
      chk("bp_count", 64'(fifo_count), 64'd4);
      chk("bp_overflow", 64'(overflow), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_model_drop", 64'(n_drop_m), 64'd1);
      hold_mode = 0;
      wait_drain("bp_drain");
      chk("bp_sticky", 64'(overflow), 64'd1);

      // Full FIFO with push and pop in the same cycle.
      do_reset();
      for (int i = 0; i < 16; i++) drive_sample(i * 9 - 70, 1, 0);
      tick();
      tick();
      chk("sim_full", 64'(fifo_count), 64'd4);
      drive_sample(11, 1, 0);
      drive_sample(22, 1, 0);
      drive_sample(33, 1, 0);
      drive_sample(44, 1, 0);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("sim_count", 64'(fifo_count), 64'd4);
      chk("sim_overflow", 64'(overflow), 64'd0);
      wait_drain("sim_drain");

      // Input during DRAIN is ignored and flagged.
      do_reset();
      drive_sample(77, 1, 0);
      flush_pulse();
      in_valid = 1'b1;
      in_data = 32'd99;
      tick();
      in_valid = 1'b0;
      wait_flush_done("drn_done");
      chk("drn_overflow", 64'(overflow), 64'd1);
      chk("drn_data", 64'(out_data), 64'h0000004D);
      wait_drain("drn_drain");

      // Reset with the pipeline and two lanes occupied.
      do_reset();
      drive_sample(10, 1, 0);
      drive_sample(20, 1, 0);
      drive_sample(30, 1, 0);
      drive_sample(40, 1, 0);
      drive_sample(50, 1, 0);
      drive_sample(60, 1, 0);
      drive_sample(70, 1, 0);
      drive_sample(80, 1, 0);
      chk("mid_pre_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_valid", 64'(out_valid), 64'd0);
      chk("mid_data", 64'(out_data), 64'd0);
      chk("mid_count", 64'(fifo_count), 64'd0);
      chk("mid_in_ready", 64'(in_ready), 64'd0);
      chk("mid_flush_done", 64'(flush_done), 64'd0);
      exp_q.delete();
      lanes_m.delete();
      tick();
      rst = 1'b0;
      tick();
      drive_sample(-5, 2, 1);
      drive_sample(6, 2, 1);
      drive_sample(-7, 2, 1);
      drive_sample(8, 2, 1);
      for (int i = 0; i < 4; i++) tick();
      chk("mid_one_word", 64'(fifo_count), 64'd1);
      wait_drain("mid_drain");

      // Randomized traffic honoring in_ready, with random flushes and backpressure.
      do_reset();
      rnd_ready = 1;
      for (int c = 0; c < 1500; c++) begin
         in_valid = 1'b0;
         flush = 1'b0;
         if (in_ready) begin
            if ($urandom_range(0, 3) != 0) begin
               int x;
               int sc;
               int sh;
               if ($urandom_range(0, 1) == 1) begin
                  x  = int'($urandom_range(0, 4000)) - 2000;
                  sc = int'($urandom_range(1, 64));
                  sh = int'($urandom_range(0, 8));
               end else begin
                  x  = int'($urandom);
                  sc = int'($urandom_range(0, 65535));
                  sh = int'($urandom_range(0, 31));
               end
               in_valid  = 1'b1;
               in_data   = 32'(x);
               cfg_scale = SCALE_W'(sc);
               cfg_shift = 5'(sh);
               model_accept(x, sc, sh);
            end
            if ($urandom_range(0, 24) == 0) begin
               flush = 1'b1;
               model_flush();
            end
         end
         tick();
      end
      in_valid = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      rnd_ready = 0;
      wait_drain("rand_drain");
      chk("rand_overflow", 64'(overflow), 64'd0);
      chk("flush_done_count", 64'(n_fd_seen), 64'(n_flush_exp));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
